// File: rtl/pwl_activation_unit.sv
// pwl_activation_unit
// Pipelined piecewise-linear activation: y = a[s]*|x| + b[s], with s taken from |x|.
// Negative inputs are folded with sigmoid (ONE - r) or tanh (-r) symmetry, chosen per sample.
// Four stages (S1 table lookup, S2 multiply, S3 round/offset/saturate, S4 fold into out_data)
// share a single advance enable, so the pipe holds as a whole under back-pressure.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_data  input stream, signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
//   in_mode                    0 = sigmoid symmetry, 1 = tanh symmetry (travels with sample)
//   out_valid/out_ready        output stream handshake
//   out_data                   saturated signed result
//   cfg_we/cfg_addr/cfg_a/cfg_b coefficient table write port
module pwl_activation_unit #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 12,
   parameter int unsigned NUM_SEG    = 16,
   parameter int unsigned SEG_SHIFT  = 10,
   localparam int unsigned SEG_BITS  = $clog2(NUM_SEG)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  cfg_we,
   input  logic [SEG_BITS-1:0]   cfg_addr,
   input  logic [DATA_WIDTH-1:0] cfg_a,
   input  logic [DATA_WIDTH-1:0] cfg_b
);

   localparam int unsigned AX_W  = DATA_WIDTH + 1;
   localparam int unsigned P_W   = 2 * DATA_WIDTH + 1;
   localparam int unsigned SUM_W = P_W + 1;

   localparam logic [AX_W-1:0]         SEG_MAX = AX_W'(NUM_SEG - 1);
   localparam logic signed [P_W-1:0]   RND     = P_W'(1 << (FRAC_BITS - 1));
   localparam logic signed [SUM_W-1:0] ONE_S   = SUM_W'(1 << FRAC_BITS);
   localparam logic signed [SUM_W-1:0] SAT_HI  = SUM_W'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_LO  = ~SAT_HI;

   // Clamp a wide signed value into the DATA_WIDTH signed range
   function automatic logic [DATA_WIDTH-1:0] sat_w(input logic signed [SUM_W-1:0] v);
      logic [DATA_WIDTH-1:0] res;
      if (v > SAT_HI) begin
         res = DATA_WIDTH'(SAT_HI);
      end else if (v < SAT_LO) begin
         res = DATA_WIDTH'(SAT_LO);
      end else begin
         res = DATA_WIDTH'(v);
      end
      return res;
   endfunction

   // Coefficient table
   logic [DATA_WIDTH-1:0] tab_a_q [NUM_SEG];
   logic [DATA_WIDTH-1:0] tab_b_q [NUM_SEG];

   // Pipeline registers
   logic                   v1_q, v2_q, v3_q, out_valid_q;
   logic [DATA_WIDTH-1:0]  a1_q, b1_q, b2_q, r3_q, out_data_q;
   logic [AX_W-1:0]        ax1_q;
   logic signed [P_W-1:0]  p2_q;
   logic                   neg1_q, neg2_q, neg3_q;
   logic                   mode1_q, mode2_q, mode3_q;

   // Combinational stage logic
   logic                   adv_c;
   logic [AX_W-1:0]        x_ext_c, ax_c, seg_raw_c;
   logic [SEG_BITS-1:0]    seg_c;
   logic signed [P_W-1:0]  p_c, rnd_c, shr_c;
   logic signed [SUM_W-1:0] sum_c, r_ext_c;
   logic [DATA_WIDTH-1:0]  r_c, y_c;

   // Whole pipe moves when the output slot is empty or being drained
   assign adv_c     = !out_valid_q | out_ready;
   assign in_ready  = adv_c;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   // S1: magnitude in one extra bit so the most negative input has a representable |x|
   always_comb begin
      x_ext_c   = {in_data[DATA_WIDTH-1], in_data};
      ax_c      = in_data[DATA_WIDTH-1] ? (~x_ext_c + AX_W'(1)) : x_ext_c;
      seg_raw_c = ax_c >> SEG_SHIFT;
      seg_c     = (seg_raw_c > SEG_MAX) ? SEG_BITS'(NUM_SEG - 1) : SEG_BITS'(seg_raw_c);
   end

   // S2: |x| is non-negative, zero-extended before the signed multiply
   always_comb begin
      p_c = P_W'($signed(a1_q)) * P_W'($signed({1'b0, ax1_q}));
   end

   // S3: round half up, add offset, saturate
   always_comb begin
      rnd_c = p2_q + RND;
      shr_c = rnd_c >>> FRAC_BITS;
      sum_c = SUM_W'(shr_c) + SUM_W'($signed(b2_q));
      r_c   = sat_w(sum_c);
   end

   // S4: symmetry fold for negative inputs
   always_comb begin
      r_ext_c = SUM_W'($signed(r3_q));
      y_c     = r3_q;
      if (neg3_q) begin
         if (mode3_q) begin
            y_c = sat_w(-r_ext_c);
         end else begin
            y_c = sat_w(ONE_S - r_ext_c);
         end
      end
   end

   // Table writes commit regardless of stalls; a same-cycle lookup sees the old entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_SEG); i++) begin
            tab_a_q[i] <= '0;
            tab_b_q[i] <= '0;
         end
      end else if (cfg_we) begin
         tab_a_q[cfg_addr] <= cfg_a;
         tab_b_q[cfg_addr] <= cfg_b;
      end
   end

   // Stage registers, all gated by the shared advance enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         out_valid_q <= 1'b0;
         a1_q        <= '0;
         b1_q        <= '0;
         ax1_q       <= '0;
         neg1_q      <= 1'b0;
         mode1_q     <= 1'b0;
         p2_q        <= '0;
         b2_q        <= '0;
         neg2_q      <= 1'b0;
         mode2_q     <= 1'b0;
         r3_q        <= '0;
         neg3_q      <= 1'b0;
         mode3_q     <= 1'b0;
         out_data_q  <= '0;
      end else if (adv_c) begin
         v1_q        <= in_valid;
         a1_q        <= tab_a_q[seg_c];
         b1_q        <= tab_b_q[seg_c];
         ax1_q       <= ax_c;
         neg1_q      <= in_data[DATA_WIDTH-1];
         mode1_q     <= in_mode;

         v2_q        <= v1_q;
         p2_q        <= p_c;
         b2_q        <= b1_q;
         neg2_q      <= neg1_q;
         mode2_q     <= mode1_q;

         v3_q        <= v2_q;
         r3_q        <= r_c;
         neg3_q      <= neg2_q;
         mode3_q     <= mode2_q;

         out_valid_q <= v3_q;
         out_data_q  <= y_c;
      end
   end

endmodule

// File: tb/tb_pwl_activation_unit.sv
// tb_pwl_activation_unit
// Directed vectors for pwl_activation_unit: table-driven single samples with hand-computed
// results, plus sequences for same-cycle config, back-pressure and mid-stream reset.
module tb_pwl_activation_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_a;
   logic [15:0] cfg_b;

   int n_tests = 0;
   int n_fail  = 0;

   pwl_activation_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_a     (cfg_a),
      .cfg_b     (cfg_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   seg;
      int   a;
      int   b;
      logic mode;
      int   x;
      int   exp;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // All tasks start and end at 1 time unit after a rising edge
   task automatic cfg_write(input int addr, input int a, input int b);
      cfg_we   = 1'b1;
      cfg_addr = 4'(addr);
      cfg_a    = 16'(a);
      cfg_b    = 16'(b);
      @(posedge clk); #1;
      cfg_we   = 1'b0;
   endtask

   // Called right after the accepting edge; lat counts that edge as 1
   task automatic wait_out(output int lat, output int y);
      lat = 1;
      while (!out_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      y = int'($signed(out_data));
      if (out_valid && out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_one(input logic m, input int x, output int lat, output int y);
      int n;
      in_mode  = m;
      in_data  = 16'(x);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(lat, y);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, y;
      int xs [8];
      int acc, got, cyc, stall_acc, ir9, seen;
      logic hs_in, hs_out, held_v, stable_ok;
      logic [15:0] held;

      vecs[0]  = '{0,  1024,   2048,   1'b0,      0,   2048};
      vecs[1]  = '{0,  1024,   2048,   1'b0,   -512,   1920};
      vecs[2]  = '{0,  1024,   2048,   1'b0,    512,   2176};
      vecs[3]  = '{0,  4096,      0,   1'b1,   -512,   -512};
      vecs[4]  = '{15,    0,   4096,   1'b1, -32768,  -4096};
      vecs[5]  = '{15,    0,   4096,   1'b0, -32768,      0};
      vecs[6]  = '{2,  32767,  32767,  1'b0,   2048,  32767};
      vecs[7]  = '{2,  32767,  32767,  1'b1,  -2048, -32767};
      vecs[8]  = '{2,  32767,  32767,  1'b0,  -2048, -28671};
      vecs[9]  = '{1, -32768, -32768,  1'b0,   1024, -32768};
      vecs[10] = '{1, -32768, -32768,  1'b1,  -1024,  32767};
      vecs[11] = '{1, -32768, -32768,  1'b0,  -1024,  32767};
      vecs[12] = '{2,     -1,      0,  1'b0,   2048,      0};
      vecs[13] = '{2,     -1,      0,  1'b0,   2049,     -1};
      vecs[14] = '{15,     1,      5,  1'b0,  32767,     13};
      vecs[15] = '{0,   4096,      0,  1'b1,   1023,   1023};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 1'b0;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_a     = '0;
      cfg_b     = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", int'(in_ready), 1);

      // Table-driven single samples
      for (int i = 0; i < NVEC; i++) begin
         cfg_write(vecs[i].seg, vecs[i].a, vecs[i].b);
         send_one(vecs[i].mode, vecs[i].x, lat, y);
         chk($sformatf("vec%0d_latency", i), lat, 4);
         chk($sformatf("vec%0d_y", i), y, vecs[i].exp);
      end

      // Write in the same cycle as the accept: old entry used, new entry afterwards
      cfg_write(3, 0, 100);
      cfg_we   = 1'b1;
      cfg_addr = 4'd3;
      cfg_a    = 16'd0;
      cfg_b    = 16'd200;
      in_valid = 1'b1;
      in_data  = 16'd3072;
      in_mode  = 1'b0;
      @(posedge clk); #1;
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      wait_out(lat, y);
      chk("cfg_same_cycle_old", y, 100);
      send_one(1'b0, 3072, lat, y);
      chk("cfg_after_write_new", y, 200);

      // Back-pressure: 8 samples, out_ready low for the first 10 cycles
      cfg_write(0, 4096, 0);
      for (int i = 0; i < 8; i++) xs[i] = 10 * (i + 1);
      acc = 0; got = 0; cyc = 0; stall_acc = -1; ir9 = -1;
      held_v = 1'b0; stable_ok = 1'b1; held = '0;
      in_valid = 1'b1;
      in_data  = 16'(xs[0]);
      in_mode  = 1'b0;
      while (got < 8 && cyc < 60) begin
         out_ready = (cyc >= 10);
         #1;
         hs_in  = in_valid & in_ready;
         hs_out = out_valid & out_ready;
         if (hs_in) acc++;
         if (cyc == 9) begin
            stall_acc = acc;
            ir9 = int'(in_ready);
         end
         if (out_valid && !out_ready) begin
            if (held_v && out_data !== held) stable_ok = 1'b0;
            held   = out_data;
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (hs_out) begin
            chk($sformatf("bp_order%0d", got), int'($signed(out_data)), xs[got]);
            got++;
         end
         @(posedge clk); #1;
         if (hs_in) begin
            if (acc < 8) in_data = 16'(xs[acc]);
            else in_valid = 1'b0;
         end
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_accepts_while_stalled", stall_acc, 4);
      chk("bp_in_ready_stalled", ir9, 0);
      chk("bp_out_count", got, 8);
      chk("bp_data_stable", int'(stable_ok), 1);
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("bp_no_duplicates", seen, 0);

      // Reset with the output slot full and three more samples in flight
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(i + 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("pre_rst_out_valid", int'(out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_out_data", int'(out_data), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("rst_drops_in_flight", seen, 0);
      chk("post_rst_in_ready", int'(in_ready), 1);
      send_one(1'b0, 100, lat, y);
      chk("post_rst_table_pos", y, 0);
      send_one(1'b0, -100, lat, y);
      chk("post_rst_table_neg_sigmoid", y, 4096);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
